// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter that lets NUM_REQ valid/ready producers share a single
// synchronous FIFO write port. A producer holds the grant for at most
// BURST_LEN words, or until it drops valid. The FIFO full flag stalls the
// burst without giving up the grant. There is one IDLE cycle between grants.
//
// Ports
//   clk           single clock, rising edge
//   reset         asynchronous, active-high, clears all state immediately
//   req_valid     per-producer "word available"
//   req_data      packed producer words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-producer "word accepted this cycle" (when valid is also high)
//   fifo_full     FIFO full flag, sampled combinationally in the write cycle
//   fifo_write    FIFO write strobe
//   fifo_data_in  FIFO write data (granted producer's word, always driven)
//   grant_valid   a producer currently holds the grant
//   grant_id      index of the granted (or most recently granted) producer
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic                             fifo_full,
  output logic                             fifo_write,
  output logic [DATA_WIDTH-1:0]            fifo_data_in,
  output logic                             grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [IDX_W-1:0]      scan_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    scan_hit;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             in_grant;
  logic             granted_valid;
  logic             transfer;
  logic             rel_burst;
  logic [IDX_W-1:0] rr_next;

  // Unpack producer words and build the rotated scan order starting at rr_ptr.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic [IDX_W:0] scan_sum;

      assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];

      // One extra bit keeps rr_ptr+offset exact so the fold back below NUM_REQ
      // also works when NUM_REQ is not a power of two.
      assign scan_sum     = {1'b0, rr_ptr_q} + (IDX_W+1)'(gi);
      assign scan_idx[gi] = (scan_sum >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(scan_sum - (IDX_W+1)'(NUM_REQ))
                          : scan_sum[IDX_W-1:0];
      assign scan_hit[gi] = req_valid[scan_idx[gi]];
    end
  endgenerate

  // First hit in scan order wins: walk from the far end so the nearest
  // offset to rr_ptr is the last one written.
  always_comb begin
    pick_found = |scan_hit;
    pick_idx   = scan_idx[0];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (scan_hit[k]) begin
        pick_idx = scan_idx[k];
      end
    end
  end

  assign in_grant      = (state_q == ST_GRANT);
  assign granted_valid = req_valid[grant_idx_q];
  assign transfer      = in_grant && granted_valid && !fifo_full;
  assign rr_next       = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);

  // Ready depends only on state and fifo_full, never on req_valid.
  always_comb begin
    req_ready = '0;
    if (in_grant) begin
      req_ready[grant_idx_q] = !fifo_full;
    end
  end

  assign fifo_write   = transfer;
  assign fifo_data_in = req_word[grant_idx_q];
  assign grant_valid  = in_grant;
  assign grant_id     = grant_idx_q;

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rel_burst   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d     = ST_GRANT;
          grant_idx_d = pick_idx;
          beat_cnt_d  = '0;
        end
      end
      default: begin
        if (!granted_valid) begin
          // Producer ran dry: give the port away without writing.
          rel_burst = 1'b1;
        end else if (transfer) begin
          if (beat_cnt_q == LAST_BEAT) begin
            rel_burst = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
        // valid && full: stall, grant and beat count held.

        if (rel_burst) begin
          state_d    = ST_IDLE;
          rr_ptr_d   = rr_next;
          beat_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Drives a behavioural producer model into two arbiter instances (BURST_LEN 4
// and BURST_LEN 1) sharing the same request inputs; one is selected for
// monitoring per scenario. Expected writes are queued as each scenario loads
// its producers and are popped as the monitored DUT writes.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic             fifo_full;

  logic [NR-1:0] ready_a, ready_b;
  logic          write_a, write_b;
  logic [DW-1:0] dout_a, dout_b;
  logic          gv_a, gv_b;
  logic [1:0]    gid_a, gid_b;

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(4)) u_dut_b4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .fifo_full(fifo_full), .fifo_write(write_a),
    .fifo_data_in(dout_a), .grant_valid(gv_a), .grant_id(gid_a)
  );

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) u_dut_b1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .fifo_full(fifo_full), .fifo_write(write_b),
    .fifo_data_in(dout_b), .grant_valid(gv_b), .grant_id(gid_b)
  );

  logic          use_b1 = 1'b0;
  logic [NR-1:0] m_ready;
  logic          m_write;
  logic [DW-1:0] m_dout;
  logic          m_gv;
  logic [1:0]    m_gid;

  assign m_ready = use_b1 ? ready_b : ready_a;
  assign m_write = use_b1 ? write_b : write_a;
  assign m_dout  = use_b1 ? dout_b  : dout_a;
  assign m_gv    = use_b1 ? gv_b    : gv_a;
  assign m_gid   = use_b1 ? gid_b   : gid_a;

  // Producer model and scoreboard
  logic [7:0]  pw [NR][32];
  int          phead [NR];
  int          pcnt [NR];
  int          eptr [NR];
  int          acc_tot [NR];
  logic        acc [NR];
  logic [15:0] sbq [$];

  int n_checks = 0;
  int n_pass   = 0;

  logic       tr_gv [64];
  logic       tr_fw [64];
  logic [1:0] tr_gid [64];
  int         tr_n;

  logic bp_armed, bp_mon, fair_mon, bad12;
  int   bp_left, full_cycles;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input int p, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      pw[p][pcnt[p]] = base + 8'(k);
      pcnt[p]++;
    end
  endtask

  task automatic push_exp(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      sbq.push_back({8'(p), pw[p][eptr[p]]});
      eptr[p]++;
    end
  endtask

  function automatic int fw_sum(input int a, input int b);
    int s = 0;
    for (int k = a; k <= b; k++) s += tr_fw[k] ? 1 : 0;
    return s;
  endfunction

  // Runs at the negative edge: records handshakes and checks writes.
  task automatic sample();
    logic [15:0] e;
    for (int i = 0; i < NR; i++) acc[i] = req_valid[i] && m_ready[i];
    if (m_write) begin
      $display("write id=%0d data=0x%02h", m_gid, m_dout);
      check_eq("wr_handshake", 32'(acc[m_gid]), 1);
      check_eq("sb_nonempty", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check_eq("wr_id", 32'(m_gid), 32'(e[15:8]));
        check_eq("wr_data", 32'(m_dout), 32'(e[7:0]));
      end
    end
    if (bp_mon && fifo_full) begin
      full_cycles++;
      check_eq("bp_ready2", 32'(m_ready[2]), 0);
      check_eq("bp_write", 32'(m_write), 0);
      check_eq("bp_grant_held", 32'(m_gv), 1);
      check_eq("bp_grant_id", 32'(m_gid), 2);
    end
    if (fair_mon && (m_ready[1] || m_ready[2] || (m_gv && (m_gid == 2'd1 || m_gid == 2'd2))))
      bad12 = 1'b1;
    if (tr_n < 64) begin
      tr_gv[tr_n] = m_gv; tr_fw[tr_n] = m_write; tr_gid[tr_n] = m_gid;
      tr_n++;
    end
  endtask

  // Runs just after the positive edge: retires accepted words, drives inputs.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin phead[i]++; acc_tot[i]++; end
      acc[i] = 1'b0;
      req_valid[i] = (phead[i] < pcnt[i]);
      req_data[i*DW +: DW] = pw[i][phead[i] % 32];
    end
    if (bp_armed && acc_tot[2] >= 2) begin
      fifo_full = 1'b1; bp_left = 3; bp_armed = 1'b0;
    end else if (bp_left > 0) begin
      bp_left--;
      if (bp_left == 0) fifo_full = 1'b0;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(negedge clk); sample();
      @(posedge clk); #1; drive();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; fifo_full = 1'b0;
    bp_armed = 1'b0; bp_left = 0; bp_mon = 1'b0; fair_mon = 1'b0;
    for (int i = 0; i < NR; i++) begin
      phead[i] = 0; pcnt[i] = 0; eptr[i] = 0; acc_tot[i] = 0; acc[i] = 1'b0;
    end
    sbq.delete();
    drive();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    tr_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_valid = '0; req_data = 32'h1234_565A; fifo_full = 1'b0;
    bp_armed = 1'b0; bp_mon = 1'b0; fair_mon = 1'b0; bad12 = 1'b0;
    bp_left = 0; full_cycles = 0; tr_n = 0;
    for (int i = 0; i < NR; i++) begin
      phead[i] = 0; pcnt[i] = 0; eptr[i] = 0; acc_tot[i] = 0; acc[i] = 1'b0;
    end

    // Reset state
    #3;
    check_eq("rst_ready", 32'(m_ready), 0);
    check_eq("rst_write", 32'(m_write), 0);
    check_eq("rst_gv", 32'(m_gv), 0);
    check_eq("rst_gid", 32'(m_gid), 0);
    check_eq("rst_dout", 32'(m_dout), 32'h5A);

    // Single producer, valid drops after three words
    do_reset();
    load(1, 3, 8'hA1); push_exp(1, 3);
    drive(); run_cycles(7);
    check_eq("single_s0_idle", 32'(tr_gv[0]), 0);
    check_eq("single_gv", 32'(tr_gv[1]), 1);
    check_eq("single_gid", 32'(tr_gid[1]), 1);
    check_eq("single_writes", 32'(fw_sum(1, 3)), 3);
    check_eq("single_rel_gv", 32'(tr_gv[4]), 1);
    check_eq("single_rel_fw", 32'(tr_fw[4]), 0);
    check_eq("single_after_idle", 32'(tr_gv[5]), 0);
    // rr_ptr is now 2: producer 2 must beat producer 0
    load(0, 1, 8'h10); load(2, 1, 8'h20);
    push_exp(2, 1); push_exp(0, 1);
    drive(); tr_n = 0; run_cycles(8);
    check_eq("rr_after_single", 32'(tr_gid[1]), 2);
    check_eq("single_sb_empty", 32'(sbq.size()), 0);

    // Full contention
    do_reset();
    load(0, 8, 8'h00); load(1, 4, 8'h10); load(2, 4, 8'h20); load(3, 4, 8'h30);
    push_exp(0, 4); push_exp(1, 4); push_exp(2, 4); push_exp(3, 4); push_exp(0, 4);
    drive(); run_cycles(28);
    for (int g = 0; g < 5; g++) begin
      check_eq("cont_gv", 32'(tr_gv[1 + 5*g]), 1);
      check_eq("cont_gid", 32'(tr_gid[1 + 5*g]), 32'(g % 4));
    end
    check_eq("cont_idle_gap", 32'(tr_gv[5]), 0);
    check_eq("cont_16_in_20", 32'(fw_sum(1, 20)), 16);
    check_eq("cont_sb_empty", 32'(sbq.size()), 0);

    // Backpressure on producer 2
    do_reset();
    bp_armed = 1'b1; bp_mon = 1'b1; full_cycles = 0;
    load(2, 4, 8'hC0); push_exp(2, 4);
    drive(); run_cycles(10);
    check_eq("bp_full_cycles", 32'(full_cycles), 3);
    check_eq("bp_resume_writes", 32'(fw_sum(6, 7)), 2);
    check_eq("bp_total_writes", 32'(fw_sum(0, 9)), 4);
    check_eq("bp_release", 32'(tr_gv[8]), 0);
    check_eq("bp_sb_empty", 32'(sbq.size()), 0);

    // Fairness with wrap: producers 0 and 3
    do_reset();
    fair_mon = 1'b1; bad12 = 1'b0;
    load(0, 8, 8'h40); load(3, 8, 8'h70);
    push_exp(0, 4); push_exp(3, 4); push_exp(0, 4); push_exp(3, 4);
    drive(); run_cycles(22);
    for (int g = 0; g < 4; g++)
      check_eq("fair_gid", 32'(tr_gid[1 + 5*g]), (g % 2 == 0) ? 0 : 3);
    check_eq("fair_no_1_2", 32'(bad12), 0);
    check_eq("fair_sb_empty", 32'(sbq.size()), 0);

    // Reset during the second beat of producer 1
    do_reset();
    load(1, 4, 8'h50); push_exp(1, 1);
    drive(); run_cycles(2);
    @(negedge clk);
    check_eq("rstmid_pre_write", 32'(m_write), 1);
    check_eq("rstmid_pre_data", 32'(m_dout), 32'h51);
    reset = 1'b1;
    #1;
    check_eq("rstmid_write", 32'(m_write), 0);
    check_eq("rstmid_ready", 32'(m_ready), 0);
    check_eq("rstmid_gv", 32'(m_gv), 0);
    load(0, 4, 8'h60); load(2, 4, 8'h62); load(3, 4, 8'h63);
    push_exp(0, 4); push_exp(1, 3); push_exp(2, 4); push_exp(3, 4);
    @(posedge clk); #1; drive();
    @(posedge clk); #1; reset = 1'b0;
    tr_n = 0; run_cycles(22);
    check_eq("rstmid_first_gv", 32'(tr_gv[1]), 1);
    check_eq("rstmid_first_gid", 32'(tr_gid[1]), 0);
    check_eq("rstmid_sb_empty", 32'(sbq.size()), 0);

    // BURST_LEN = 1 instance, producers 0 and 1
    do_reset();
    use_b1 = 1'b1;
    load(0, 4, 8'h80); load(1, 4, 8'h90);
    for (int k = 0; k < 4; k++) begin push_exp(0, 1); push_exp(1, 1); end
    drive(); run_cycles(16);
    for (int g = 0; g < 4; g++) begin
      check_eq("b1_gid", 32'(tr_gid[1 + 2*g]), 32'(g % 2));
      check_eq("b1_write", 32'(tr_fw[1 + 2*g]), 1);
    end
    for (int g = 0; g < 3; g++) check_eq("b1_idle", 32'(tr_gv[2 + 2*g]), 0);
    check_eq("b1_total", 32'(fw_sum(0, 15)), 8);
    check_eq("b1_sb_empty", 32'(sbq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ independent producers. Each producer uses a valid/ready handshake; the arbiter grants one producer at a time for a bounded burst, steers its data onto the FIFO write port and honours the FIFO `full` flag. It sits directly in front of the FIFO write side; the FIFO's read side is untouched.

## Interface
- NUM_REQ, 4, number of producers (≥2)
- DATA_WIDTH, 8, word width, equal to the FIFO DATA_WIDTH
- BURST_LEN, 4, maximum words per grant (≥1)

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  NUM_REQ  bit i: producer i has a word
- req_data  in  NUM_REQ*DATA_WIDTH  producer i word at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  bit i: producer i word accepted this cycle when valid is also high
- fifo_full  in  1  FIFO full flag
- fifo_write  out  1  FIFO write strobe
- fifo_data_in  out  DATA_WIDTH  FIFO write data
- grant_valid  out  1  a producer currently holds the grant
- grant_id  out  $clog2(NUM_REQ)  index of granted producer

## Operation
- States: IDLE, GRANT. Registers: state, grant_idx, rr_ptr (both $clog2(NUM_REQ) bits), beat_cnt ($clog2(BURST_LEN+1) bits).
- IDLE: if any req_valid bit is high, select the first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. Latch it into grant_idx, clear beat_cnt, go to GRANT. With no request, remain in IDLE.
- GRANT:
  - req_ready[grant_idx] = !fifo_full. All other req_ready bits are 0.
  - A transfer occurs when req_valid[grant_idx] && req_ready[grant_idx].
  - fifo_write = transfer.
  - fifo_data_in = req_data slice for grant_idx. It is always driven and is meaningful only when fifo_write = 1.
  - On a transfer, beat_cnt increments. If beat_cnt was BURST_LEN-1, release.
  - If req_valid[grant_idx] = 0, release without writing.
  - fifo_full = 1 with valid high is a stall: no write, beat_cnt held, grant kept indefinitely.
  - Release: state goes to IDLE; rr_ptr = (grant_idx+1) mod NUM_REQ; beat_cnt = 0.
- IDLE outputs: req_ready = 0, fifo_write = 0.
- grant_valid = (state == GRANT); grant_id = grant_idx.
- req_ready does not depend on req_valid (no combinational valid→ready path).
- Producer rule: while valid && !ready, a producer holds valid and its data stable.
- Wrap-around: rr_ptr and the scan wrap modulo NUM_REQ. Non-power-of-two NUM_REQ wraps explicitly at NUM_REQ-1 → 0.
- Reset mid-burst: state goes to IDLE and all registers clear asynchronously. The in-flight word is not written and the producer retries after reset.

## Timing
- Reset values: state IDLE, rr_ptr 0, grant_idx 0, beat_cnt 0. Outputs: req_ready 0, fifo_write 0, grant_valid 0, grant_id 0, fifo_data_in = req_data[DATA_WIDTH-1:0].
- Arbitration latency: request seen in IDLE at edge N → GRANT from N+1. The first write can occur in the cycle after the edge at N+1.
- Sustained rate: one word per cycle inside a burst. One IDLE cycle between grants, so full-load efficiency is BURST_LEN/(BURST_LEN+1).
- fifo_full is sampled combinationally in the same cycle as the write. The FIFO must assert full before it would overflow.
- Simultaneous events:
  - The last beat together with valid still high releases anyway, and the producer re-arbitrates.
  - A release together with new requests is handled by the scan in the following IDLE cycle, using the updated rr_ptr.

## Test plan
- Single producer: req_valid[1] with words 0xA1, 0xA2, 0xA3, then valid drops; BURST_LEN=4. Expect grant_id=1 one cycle later, fifo_write for 3 consecutive cycles with data A1, A2, A3, release on the valid-low cycle, and rr_ptr=2.
- Full contention: all 4 producers continuously valid, BURST_LEN=4. Expect grant order 0,1,2,3,0, 4 writes each, one idle cycle between grants, and 16 writes in 20 cycles from the first grant.
- Backpressure: fifo_full high for 3 cycles after the 2nd beat of producer 2's burst. Expect req_ready[2]=0 and fifo_write=0 for those 3 cycles with grant held; after full drops, exactly 2 more writes complete the 4-beat burst.
- Fairness with wrap: producers 0 and 3 continuously valid. Expect grant order 0,3,0,3; producers 1 and 2 are never granted and never see ready.
- Reset mid-burst: assert reset during the 2nd beat of producer 1. Expect fifo_write, req_ready and grant_valid to go 0 in the same cycle without waiting for a clock edge. After release with all producers valid, the first grant goes to producer 0.
- BURST_LEN=1: producers 0 and 1 continuously valid. Expect alternating single writes 0,1,0,1, each followed by one IDLE cycle.
